// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial add/subtract unit: default width,
// its top bit index, and the controller state encodings.
package serial_adder_pkg;

  localparam int SA_WIDTH   = 32;
  localparam int SA_IDX_MAX = SA_WIDTH - 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit full adder built from two half adders and an OR of their carries.
// The half adder lives here because it is only ever used by this cell.
module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

module full_adder_1bit (
  input  logic A,
  input  logic B,
  input  logic CI,
  output logic S,
  output logic CO
);
  logic s0_s;
  logic c0_s;
  logic c1_s;

  half_adder u_ha0 (
    .a_i (A),
    .b_i (B),
    .s_o (s0_s),
    .c_o (c0_s)
  );

  half_adder u_ha1 (
    .a_i (s0_s),
    .b_i (CI),
    .s_o (S),
    .c_o (c1_s)
  );

  assign CO = c0_s | c1_s;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder step per clock, LSB first.
// Result and flags land together with a one-cycle DONE pulse.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int DATA_WIDTH = SA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  SUB,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [DATA_WIDTH-1:0] Y,
  output logic                  CO,
  output logic                  OVF
);
  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] sa_q, sa_d;
  logic [DATA_WIDTH-1:0] sb_q, sb_d;
  logic [DATA_WIDTH-1:0] r_q, r_d;
  logic [DATA_WIDTH-1:0] y_q, y_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  carry_q, carry_d;
  logic                  co_q, co_d;
  logic                  ovf_q, ovf_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  fa_s;
  logic                  fa_co;
  logic [DATA_WIDTH-1:0] r_shift_s;

  full_adder_1bit u_fa (
    .A  (sa_q[0]),
    .B  (sb_q[0]),
    .CI (carry_q),
    .S  (fa_s),
    .CO (fa_co)
  );

  assign r_shift_s = {fa_s, r_q[DATA_WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    r_d     = r_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          sa_d    = A;
          sb_d    = B ^ {DATA_WIDTH{SUB}};
          carry_d = SUB;
          r_d     = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        r_d     = r_shift_s;
        sa_d    = {1'b0, sa_q[DATA_WIDTH-1:1]};
        sb_d    = {1'b0, sb_q[DATA_WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        // MSB step: the carry-in here is the carry into the sign bit.
        if (cnt_q == CNT_LAST) begin
          y_d     = r_shift_s;
          co_d    = fa_co;
          ovf_d   = carry_q ^ fa_co;
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      r_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      r_q     <= r_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign Y    = y_q;
  assign CO   = co_q;
  assign OVF  = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: stimulus pushes expected results,
// a negedge monitor pops and checks them whenever DONE is presented.
module tb_serial_adder;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] y;
    logic         co;
    logic         ovf;
    int           done_cyc;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         START = 1'b0;
  logic         SUB = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] Y;
  logic         CO;
  logic         OVF;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  serial_adder #(.DATA_WIDTH(W)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .SUB   (SUB),
    .A     (A),
    .B     (B),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .Y     (Y),
    .CO    (CO),
    .OVF   (OVF)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every DONE pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (!RST && DONE === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got DONE=1 expected no pending result (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result_y", Y, e.y);
        check("result_co", W'(CO), W'(e.co));
        check("result_ovf", W'(OVF), W'(e.ovf));
        check("done_cycle", W'(cyc), W'(e.done_cyc));
      end
    end
  end

  // Drive one START; expectation is queued only when 'expect_it' is set.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input logic [W-1:0] ey, input logic eco, input logic eovf,
                       input bit expect_it);
    exp_t e;
    @(negedge CLK);
    A = a; B = b; SUB = sub; START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    e.y = ey; e.co = eco; e.ovf = eovf; e.done_cyc = cyc + W;
    if (expect_it) sb_q.push_back(e);
    check("busy_after_start", W'(BUSY), W'(1));
  endtask

  // Finish the 34-negedge window of an operation started by issue().
  task automatic finish_op(input int already);
    repeat (33 - already) @(negedge CLK);
    check("busy_last_done_cycle", W'(BUSY), W'(1));
    @(negedge CLK);
    check("busy_dropped", W'(BUSY), W'(0));
    check("scoreboard_drained", W'(sb_q.size()), W'(0));
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    check("reset_busy", W'(BUSY), W'(0));
    check("reset_y", Y, '0);
    RST = 1'b0;

    issue(32'd5, 32'd3, 1'b0, 32'd8, 1'b0, 1'b0, 1'b1);
    finish_op(0);

    // Asynchronous reset between edges clears outputs immediately.
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    check("async_rst_busy", W'(BUSY), W'(0));
    check("async_rst_done", W'(DONE), W'(0));
    check("async_rst_y", Y, '0);
    check("async_rst_co", W'(CO), W'(0));
    check("async_rst_ovf", W'(OVF), W'(0));
    #1 RST = 1'b0;

    issue(32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    finish_op(0);
    issue(32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
    finish_op(0);
    issue(32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
    finish_op(0);
    issue(32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1);
    finish_op(0);
    issue(32'd100, 32'd100, 1'b1, 32'd0, 1'b1, 1'b0, 1'b1);
    finish_op(0);

    // START during RUN must be ignored.
    issue(32'd5, 32'd3, 1'b0, 32'd8, 1'b0, 1'b0, 1'b1);
    repeat (10) @(negedge CLK);
    A = 32'd1; B = 32'd1; SUB = 1'b0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    finish_op(11);

    // Reset mid-RUN discards the operation; the next one completes normally.
    issue(32'd5, 32'd3, 1'b0, 32'd8, 1'b0, 1'b0, 1'b0);
    repeat (15) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    check("abort_busy", W'(BUSY), W'(0));
    check("abort_y", Y, '0);
    #1 RST = 1'b0;
    issue(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b1);
    finish_op(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial add/subtract unit built around a single 1-bit full adder composed of two half adders and an OR gate. It processes one bit per clock from LSB to MSB and replaces a ripple-carry chain wherever area matters more than latency. Operands are accepted on a start pulse, and a one-cycle done pulse accompanies the 32-bit result and flags.

## Interface
- DATA_WIDTH, 32: operand/result width in bits; must be ≥2.
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  request; sampled only in IDLE.
- SUB  input  1  0 = A+B, 1 = A−B; sampled with START.
- A  input  DATA_WIDTH  operand A; sampled with START.
- B  input  DATA_WIDTH  operand B; sampled with START.
- BUSY  output  1  high in RUN and DONE states.
- DONE  output  1  one-cycle pulse: Y/CO/OVF valid.
- Y  output  DATA_WIDTH  sum/difference; held until next accepted START.
- CO  output  1  carry out of MSB; for SUB, 1 = no borrow.
- OVF  output  1  signed overflow.

## Operation
- States: IDLE, RUN, DONE; encoding is free, and a 2-bit register is sufficient.
- IDLE: on START=1 latch A into the shift register SA and (B XOR {DATA_WIDTH{SUB}}) into SB. Set the carry flop to SUB, clear the bit counter, and go to RUN.
- RUN: each cycle computes a full add of SA[0], SB[0] and the carry.
  - The sum bit shifts into the MSB of the result register R; SA and SB shift right.
  - The carry flop takes the new carry, and the counter increments.
  - When the counter reaches DATA_WIDTH−1, the step processes the MSB, then:
    - Y ← final R;
    - CO ← carry out of that step;
    - OVF ← carry-in of that step XOR carry out;
    - go to DONE.
- DONE: DONE=1 for exactly one cycle, then IDLE unconditionally.
- START in RUN or DONE is ignored; there is no queueing, and the in-flight operation is unaffected.
- Y, CO and OVF update only on the MSB step. They hold their values through IDLE and subsequent RUN cycles until the next result lands.
- Arithmetic is modulo 2^DATA_WIDTH. SUB uses two's complement: A + ~B + 1.
- Reset (any state, including mid-RUN): state IDLE; BUSY=0, DONE=0, Y=0, CO=0, OVF=0; internal registers cleared. The partial operation is discarded.

## Timing
- START accepted at edge k → BUSY=1 from edge k.
- Bits processed on edges k+1 … k+DATA_WIDTH. Y/CO/OVF are valid and DONE=1 from edge k+DATA_WIDTH to k+DATA_WIDTH+1.
- BUSY=0 from edge k+DATA_WIDTH+1.
- Latency from START edge to DONE is DATA_WIDTH cycles.
- Earliest next START is sampled at edge k+DATA_WIDTH+1, giving a throughput of one operation per DATA_WIDTH+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared definitions file: width constant (default 32), its index limit, and state encodings (IDLE/RUN/DONE).
- Sub-module full_adder_1bit (S, CO, A, B, CI):
  - two existing half-adder instances;
  - an OR of their carries;
  - purely combinational; instantiated once.
- Counter width: $clog2(DATA_WIDTH).
- Expected size: ~150 lines of RTL for the top level plus the sub-module.

## Test plan
- Reset: assert RST mid-simulation with no clock edge. Required: BUSY, DONE, Y, CO and OVF all 0 immediately.
- Add: A=5, B=3, SUB=0, START at edge k. Required:
  - DONE high only between edges k+32 and k+33;
  - Y=8, CO=0, OVF=0;
  - BUSY drops at k+33.
- Wrap: A=0xFFFFFFFF, B=1, SUB=0. Required: Y=0, CO=1, OVF=0.
- Overflow: A=0x7FFFFFFF, B=1, SUB=0. Required: Y=0x80000000, CO=0, OVF=1.
- Subtract: A=3, B=5, SUB=1. Required: Y=0xFFFFFFFE, CO=0, OVF=0.
  - Follow with A=0x80000000, B=1, SUB=1. Required: Y=0x7FFFFFFF, CO=1, OVF=1.
- Busy/abort:
  - Pulse START with A=1, B=1 at cycle 10 of an in-flight 5+3. Required: result 8, timing unchanged.
  - Assert RST at cycle 15 of a new operation. Required: immediate IDLE with outputs 0; next START yields a correct result after 32 cycles.
